// File: rtl/tmr_apb_sequencer_if.sv
// -----------------------------------------------------------------------------
// tmr_apb_sequencer_if
// APB bus bundle between the timer sequencer (master) and the timer register
// block (slave).
//   psel, penable, pwrite : master transfer controls
//   paddr  [ADDR_WIDTH]   : register address
//   pwdata [DATA_WIDTH]   : write data
//   pready, pslverr       : slave completion and error response
// -----------------------------------------------------------------------------
interface tmr_apb_sequencer_if #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, pslverr
    );
endinterface

// File: rtl/tmr_apb_sequencer.sv
// -----------------------------------------------------------------------------
// tmr_apb_sequencer
// Drives a timer peripheral over APB: on a start command it loads the reload
// register, loads and enables the timer, then watches the terminal flag.
// Supports a tick-counted pause, an abort, and stops on APB slave errors.
//   pclk, preset                : clock, synchronous active-high reset
//   cmd_valid/cmd_ready         : start-command handshake
//   cmd_tdr/down/cks/pause_len  : command fields, latched on acceptance
//   pause_req, abort, tick      : single-cycle control strobes
//   apb                         : APB master port
//   TMR_OVF, TMR_UDF            : timer overflow / underflow flags
//   busy, paused                : status levels
//   done, err                   : single-cycle status pulses
// -----------------------------------------------------------------------------
module tmr_apb_sequencer #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 3,
    parameter logic [ADDR_WIDTH-1:0] TDR_ADDR   = 3'b010,
    parameter logic [ADDR_WIDTH-1:0] TCR_ADDR   = 3'b011
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] cmd_tdr,
    input  logic                  cmd_down,
    input  logic [1:0]            cmd_cks,
    input  logic [7:0]            cmd_pause_len,
    input  logic                  pause_req,
    input  logic                  abort,
    input  logic                  tick,
    tmr_apb_sequencer_if.master   apb,
    input  logic                  TMR_OVF,
    input  logic                  TMR_UDF,
    output logic                  busy,
    output logic                  paused,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [3:0] {
        IDLE, WR_TDR, WR_LOAD, WR_EN, RUN, WR_DIS, PAUSE, WR_RES, WR_STOP, ERR
    } state_t;

    state_t                state_reg, state_next;
    logic                  acc_reg, acc_next;        // 0 = setup phase, 1 = access phase
    logic [ADDR_WIDTH-1:0] paddr_reg, paddr_next;
    logic [DATA_WIDTH-1:0] pwdata_reg, pwdata_next;
    logic                  down_reg;
    logic [1:0]            cks_reg;
    logic [7:0]            plen_reg;
    logic [7:0]            pcnt_reg, pcnt_next;
    logic                  aborted_reg, aborted_next; // suppresses done after an abort stop
    logic                  done_reg, done_next;
    logic                  accept;
    logic                  in_wr;
    logic [1:0]            flag_in, flag_rise;
    logic                  term_rise;

    function automatic logic is_wr(input state_t s);
        return (s == WR_TDR) || (s == WR_LOAD) || (s == WR_EN) ||
               (s == WR_DIS) || (s == WR_RES)  || (s == WR_STOP);
    endfunction

    // Control word: {load, 0, down, en, 00, cks}
    function automatic logic [DATA_WIDTH-1:0] tcr_word(input logic load, input logic dn,
                                                       input logic en, input logic [1:0] ck);
        logic [7:0] w;
        w = {load, 1'b0, dn, en, 2'b00, ck};
        return DATA_WIDTH'(w);
    endfunction

    // Rising-edge detection on both timer flags; index 0 = OVF, 1 = UDF.
    assign flag_in = {TMR_UDF, TMR_OVF};
    for (genvar gi = 0; gi < 2; gi++) begin : g_flag
        logic flag_reg;
        always_ff @(posedge pclk) begin
            if (preset) begin
                flag_reg <= 1'b0;
            end else begin
                flag_reg <= flag_in[gi];
            end
        end
        assign flag_rise[gi] = flag_in[gi] & ~flag_reg;
    end

    assign term_rise = down_reg ? flag_rise[1] : flag_rise[0];
    assign in_wr     = is_wr(state_reg);

    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        pcnt_next    = pcnt_reg;
        aborted_next = aborted_reg;
        done_next    = 1'b0;
        accept       = 1'b0;
        paddr_next   = paddr_reg;
        pwdata_next  = pwdata_reg;

        if (in_wr) begin
            if (!acc_reg) begin
                acc_next = 1'b1;
            end else if (apb.pready) begin
                acc_next = 1'b0;
                if (apb.pslverr) begin
                    state_next = ERR;
                end else begin
                    case (state_reg)
                        WR_TDR:  state_next = WR_LOAD;
                        WR_LOAD: state_next = WR_EN;
                        WR_EN:   state_next = RUN;
                        WR_DIS: begin
                            state_next = PAUSE;
                            pcnt_next  = plen_reg;
                        end
                        WR_RES:  state_next = RUN;
                        WR_STOP: begin
                            state_next = IDLE;
                            done_next  = ~aborted_reg;
                        end
                        default: state_next = state_reg;
                    endcase
                end
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        accept     = 1'b1;
                        state_next = WR_TDR;
                    end
                end
                RUN: begin
                    // abort beats terminal edge, terminal edge beats pause
                    if (abort) begin
                        state_next   = WR_STOP;
                        aborted_next = 1'b1;
                    end else if (term_rise) begin
                        state_next   = WR_STOP;
                        aborted_next = 1'b0;
                    end else if (pause_req) begin
                        state_next = WR_DIS;
                    end
                end
                PAUSE: begin
                    if (abort) begin
                        state_next   = WR_STOP;
                        aborted_next = 1'b1;
                    end else if (pcnt_reg == 8'd0) begin
                        state_next = WR_RES;
                    end else if (tick) begin
                        pcnt_next = pcnt_reg - 8'd1;
                    end
                end
                ERR:     state_next = IDLE;
                default: state_next = state_reg;
            endcase
        end

        // Address/data are captured once, when a write state is entered, so they
        // stay stable through setup/access and hold afterwards.
        if (is_wr(state_next) && (state_next != state_reg)) begin
            case (state_next)
                WR_TDR: begin
                    paddr_next  = TDR_ADDR;
                    pwdata_next = cmd_tdr;  // command-time value; this register is its latch
                end
                WR_LOAD: begin
                    paddr_next  = TCR_ADDR;
                    pwdata_next = tcr_word(1'b1, down_reg, 1'b0, cks_reg);
                end
                WR_EN, WR_RES: begin
                    paddr_next  = TCR_ADDR;
                    pwdata_next = tcr_word(1'b0, down_reg, 1'b1, cks_reg);
                end
                default: begin // WR_DIS, WR_STOP
                    paddr_next  = TCR_ADDR;
                    pwdata_next = tcr_word(1'b0, down_reg, 1'b0, cks_reg);
                end
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_reg   <= IDLE;
            acc_reg     <= 1'b0;
            paddr_reg   <= '0;
            pwdata_reg  <= '0;
            down_reg    <= 1'b0;
            cks_reg     <= 2'b00;
            plen_reg    <= 8'd0;
            pcnt_reg    <= 8'd0;
            aborted_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            paddr_reg   <= paddr_next;
            pwdata_reg  <= pwdata_next;
            pcnt_reg    <= pcnt_next;
            aborted_reg <= aborted_next;
            done_reg    <= done_next;
            if (accept) begin
                down_reg <= cmd_down;
                cks_reg  <= cmd_cks;
                plen_reg <= cmd_pause_len;
            end
        end
    end

    assign apb.psel    = in_wr;
    assign apb.penable = in_wr & acc_reg;
    assign apb.pwrite  = in_wr;
    assign apb.paddr   = paddr_reg;
    assign apb.pwdata  = pwdata_reg;

    assign cmd_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign paused    = (state_reg == WR_DIS) || (state_reg == PAUSE);
    assign done      = done_reg;
    assign err       = (state_reg == ERR);

endmodule

// File: doc/tmr_apb_sequencer.md
TMR_APB_SEQUENCER -- requirements
Module: tmr_apb_sequencer

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, APB data width; ADDR_WIDTH, default 3, APB address width; TDR_ADDR, default 3'b010, data register address; TCR_ADDR, default 3'b011, control register address.
REQ-002 pclk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 preset  in  1  reset, synchronous and active-high.
REQ-004 cmd_valid  in  1  start-command request.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both 1.
REQ-006 cmd_tdr  in  DATA_WIDTH  reload value for the timer.
REQ-007 cmd_down  in  1  count direction, 1=down, 0=up.
REQ-008 cmd_cks  in  2  prescaler clock select.
REQ-009 cmd_pause_len  in  8  pause length in tick pulses.
REQ-010 pause_req  in  1  single-cycle pause request.
REQ-011 abort  in  1  single-cycle stop request.
REQ-012 tick  in  1  single-cycle strobe, synchronous to pclk, used to count pause length.
REQ-013 psel, penable, pwrite  out  1 each  APB master controls.
REQ-014 paddr  out  ADDR_WIDTH  APB address.
REQ-015 pwdata  out  DATA_WIDTH  APB write data.
REQ-016 pready, pslverr  in  1 each  APB slave response.
REQ-017 TMR_OVF, TMR_UDF  in  1 each  timer overflow and underflow flags.
REQ-018 busy, paused  out  1 each  status levels.
REQ-019 done, err  out  1 each  single-cycle status pulses.

Function
REQ-020 TCR write data SHALL be composed as {load, 1'b0, down, en, 2'b00, cks}, with bit7 = load, bit5 = down, bit4 = en and bits[1:0] = cks.
REQ-021 The command fields SHALL be latched on acceptance; cmd_ready SHALL equal 1 only in state IDLE.
REQ-022 The FSM SHALL have the states IDLE, WR_TDR, WR_LOAD, WR_EN, RUN, WR_DIS, PAUSE, WR_RES, WR_STOP and ERR.
REQ-023 Every WR_* state SHALL perform exactly one APB write.
  - Setup cycle: psel=1, penable=0, pwrite=1, with paddr and pwdata valid.
  - Access cycle: penable=1, held until pready=1.
  - A transfer therefore takes a minimum of 2 cycles.
  - paddr and pwdata SHALL be stable from setup until completion.
REQ-024 Outside APB transfers, psel, penable and pwrite SHALL be 0, and paddr and pwdata SHALL hold their last values.
REQ-025 The sequence SHALL be as follows.
  - IDLE, command accepted -> WR_TDR, writing cmd_tdr to TDR_ADDR.
  - WR_TDR -> WR_LOAD, writing TCR with load=1, en=0.
  - WR_LOAD -> WR_EN, writing TCR with load=0, en=1.
  - WR_EN -> RUN.
REQ-026 In RUN, a rising edge of the terminal flag SHALL cause -> WR_STOP, writing TCR with en=0. The terminal flag is TMR_UDF when down=1 and TMR_OVF when down=0. WR_STOP completion SHALL pulse done for 1 cycle and return to IDLE.
REQ-027 In RUN, pause_req=1 SHALL cause -> WR_DIS (TCR en=0) -> PAUSE. On entry to PAUSE the pause counter SHALL be loaded with the latched pause_len.
REQ-028 In PAUSE, each tick SHALL decrement the counter. When the counter is 0, the FSM SHALL go -> WR_RES (TCR en=1, load=0) -> RUN. A pause_len of 0 SHALL resume without waiting for a tick.
REQ-029 paused SHALL be 1 in states WR_DIS and PAUSE only. busy SHALL be 1 in every state except IDLE.
REQ-030 pause_req outside RUN SHALL be ignored.
REQ-031 Terminal-flag edges SHALL be ignored outside RUN, including during PAUSE.
REQ-032 abort=1 in RUN or PAUSE SHALL cause -> WR_STOP; completion SHALL then produce no done pulse.
REQ-033 abort=1 in any other state SHALL be ignored.
REQ-034 Abort SHALL take priority over pause_req and the terminal flag in the same cycle.
REQ-035 A terminal flag edge SHALL take priority over pause_req in the same cycle.
REQ-036 pslverr=1 on a completing transfer (pready=1) SHALL cause -> ERR.
  - ERR pulses err for 1 cycle, issues no further APB transfer and returns to IDLE.
  - The timer is left as last written.
REQ-037 The edge detector for the terminal flag SHALL register TMR_OVF and TMR_UDF every cycle.

Reset
REQ-038 With preset=1 at a pclk edge, the state SHALL become IDLE.
REQ-039 Reset values SHALL be: psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, busy=0, paused=0, done=0, err=0, pause counter=0, latched command=0, flag registers=0.
REQ-040 Reset SHALL override every other input, including mid-APB-transfer, which SHALL be aborted without completion.
REQ-041 cmd_ready SHALL be 1 in the first cycle after preset deasserts.

Verification
REQ-042 cmd_tdr=8'h05, down=1, cks=2'b01, pready tied 1 -> SHALL produce the following APB writes, each with a 2-cycle setup/access pattern, then busy=1 in RUN.
  - addr 3'b010 data 8'h05.
  - addr 3'b011 data 8'hA1.
  - addr 3'b011 data 8'h31.
REQ-043 In RUN, pulse TMR_UDF -> SHALL produce a write of addr 3'b011 data 8'h21, then done=1 for 1 cycle, then IDLE with cmd_ready=1; a TMR_OVF pulse SHALL cause no response.
REQ-044 pause_len=10, pause_req in RUN -> SHALL write 8'h21, then paused=1 for the WR_DIS and PAUSE states, then after 10 ticks write 8'h31 and return to RUN; a TMR_UDF pulse during PAUSE SHALL be ignored.
REQ-045 pready held 0 for 3 cycles on WR_LOAD -> psel and penable SHALL stay 1 with paddr and pwdata stable; pslverr=1 at completion -> err pulses, no WR_EN write occurs, and the FSM returns to IDLE.
REQ-046 abort and TMR_UDF asserted in the same RUN cycle -> SHALL write 8'h21 with no done pulse.
REQ-047 preset asserted during the WR_EN access phase -> all outputs SHALL be 0 on the next cycle.
